// File: rtl/snake_pkg.sv
// snake_pkg: shared direction/state types and helpers for snake control blocks
package snake_pkg;
  typedef enum logic [1:0] {UP = 2'b00, LEFT = 2'b01, DOWN = 2'b10, RIGHT = 2'b11} dir_t;
  typedef enum logic [1:0] {IDLE, RUN, HALT} head_state_t;
  localparam int CNT_W = 6;
  function automatic dir_t opposite(dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction
endpackage

// File: rtl/snake_head_ctrl_step_timer.sv
// step_timer: counts enabled frame ticks and strobes step on every STEP_FRAMES-th one
module step_timer
  import snake_pkg::*;
#(
  parameter int STEP_FRAMES = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic step
);
  logic [CNT_W-1:0] cnt;
  assign step = enable && cnt == CNT_W'(STEP_FRAMES - 1);
  // counter wraps to zero on the stepping tick so each step takes exactly STEP_FRAMES ticks
  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (step) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/snake_head_ctrl.sv
// snake_head_ctrl: buffers direction requests, blocks reversals and steps the head with wrap-around
module snake_head_ctrl
  import snake_pkg::*;
#(
  parameter int         GRID_W      = 40,
  parameter int         GRID_H      = 30,
  parameter int         STEP_FRAMES = 6,
  parameter int         START_X     = 10,
  parameter int         START_Y     = 15,
  parameter logic [1:0] START_DIR   = 2'b11
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [1:0]                motionFlag,
  input  logic                      Load,
  input  logic                      frame_tick,
  input  logic                      start,
  input  logic                      freeze,
  output logic [$clog2(GRID_W)-1:0] head_x,
  output logic [$clog2(GRID_H)-1:0] head_y,
  output logic [1:0]                dir,
  output logic                      step_pulse,
  output logic                      running
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
  head_state_t state, state_nx;
  dir_t cur_dir, pend;
  logic step, reload;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  assign dir = cur_dir;
  // reload holds start values in IDLE and restores them on a restart out of HALT
  assign reload = state == IDLE || (state == HALT && start);
  step_timer #(.STEP_FRAMES(STEP_FRAMES)) u_timer (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clear (reload),
    .enable(state == RUN && frame_tick && !freeze),
    .step  (step)
  );
  // state register
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // next state: start leaves IDLE/HALT, freeze leaves RUN
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = RUN;
    if (state == RUN && freeze) state_nx = HALT;
    if (state == HALT && start) state_nx = RUN;
  end
  // next head cell in the pending direction, wrapping by explicit compare since grid sizes need not be powers of two
  always_comb begin
    nx = pend == LEFT ? (head_x == '0 ? X_MAX : head_x - 1'b1) :
         pend == RIGHT ? (head_x == X_MAX ? '0 : head_x + 1'b1) : head_x;
    ny = pend == UP ? (head_y == '0 ? Y_MAX : head_y - 1'b1) :
         pend == DOWN ? (head_y == Y_MAX ? '0 : head_y + 1'b1) : head_y;
  end
  // head, direction and pending request; reversal check is against the committed direction
  always_ff @(posedge Clk) begin
    if (!Reset_n || reload) begin
      head_x     <= XW'(START_X);
      head_y     <= YW'(START_Y);
      cur_dir    <= dir_t'(START_DIR);
      pend       <= dir_t'(START_DIR);
      step_pulse <= 1'b0;
    end else if (state == RUN) begin
      step_pulse <= step;
      if (step) begin
        head_x  <= nx;
        head_y  <= ny;
        cur_dir <= pend;
      end
      if (Load && dir_t'(motionFlag) != opposite(cur_dir)) pend <= dir_t'(motionFlag);
    end else begin
      step_pulse <= 1'b0;
    end
  end
  // running mirrors the state the FSM is entering
  always_ff @(posedge Clk) begin
    if (!Reset_n) running <= 1'b0;
    else running <= state_nx == RUN;
  end
endmodule

// File: tb/tb_snake_head_ctrl.sv
// tb_snake_head_ctrl: directed stimulus checked every cycle against a behavioural model plus literal pins
module tb_snake_head_ctrl;
  localparam int W = 40, H = 30, SF = 6, SX = 10, SY = 15, SD = 3;
  logic Clk = 0, Reset_n = 0, Load = 0, frame_tick = 0, start = 0, freeze = 0;
  logic [1:0] motionFlag = 0;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic step_pulse, running;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  int m_state = 0, mx = SX, my = SY, mdir = SD, mpend = SD, mcnt = 0, mstep = 0, mrun = 0;

  snake_head_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .motionFlag(motionFlag), .Load(Load),
    .frame_tick(frame_tick), .start(start), .freeze(freeze),
    .head_x(head_x), .head_y(head_y), .dir(dir), .step_pulse(step_pulse), .running(running)
  );

  always #5 Clk = ~Clk;

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: state 0 idle, 1 run, 2 halt; coordinates wrap with modulo arithmetic
  always @(posedge Clk) begin
    int od;
    if (!Reset_n) begin
      m_state = 0; mx = SX; my = SY; mdir = SD; mpend = SD; mcnt = 0; mstep = 0;
    end else begin
      mstep = 0;
      od = mdir;
      if (m_state == 0) begin
        if (start) m_state = 1;
      end else if (m_state == 1) begin
        if (freeze) m_state = 2;
        else if (frame_tick) begin
          if (mcnt == SF - 1) begin
            mcnt = 0;
            mdir = mpend;
            case (mdir)
              0: my = (my + H - 1) % H;
              1: mx = (mx + W - 1) % W;
              2: my = (my + 1) % H;
              default: mx = (mx + 1) % W;
            endcase
            mstep = 1;
          end else mcnt++;
        end
        if (Load && int'(motionFlag) != (od ^ 2)) mpend = motionFlag;
      end else if (start) begin
        m_state = 1; mx = SX; my = SY; mdir = SD; mpend = SD; mcnt = 0;
      end
    end
    mrun = (m_state == 1) ? 1 : 0;
  end

  // compare every output against the model on the falling edge
  always @(negedge Clk) begin
    if (chk_en) begin
      check("m_head_x", head_x, mx);
      check("m_head_y", head_y, my);
      check("m_dir", dir, mdir);
      check("m_step_pulse", step_pulse, mstep);
      check("m_running", running, mrun);
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
    frame_tick = 0; start = 0; freeze = 0; Load = 0;
  endtask

  task automatic ticks(int n, int gap);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1;
      cyc();
      repeat (gap) cyc();
    end
  endtask

  task automatic load(int d);
    Load = 1; motionFlag = 2'(d);
    cyc();
  endtask

  initial begin
    repeat (2) cyc();
    chk_en = 1;
    cyc();
    check("reset_x", head_x, 10);
    check("reset_y", head_y, 15);
    check("reset_dir", dir, 3);
    check("reset_running", running, 0);
    Reset_n = 1;
    start = 1; cyc();
    check("start_running", running, 1);
    ticks(5, 0);
    check("pre_step_x", head_x, 10);
    ticks(1, 0);
    check("step1_pulse", step_pulse, 1);
    check("step1_x", head_x, 11);
    check("step1_dir", dir, 3);
    cyc();
    check("step1_pulse_drop", step_pulse, 0);
    load(1);
    ticks(SF, 0);
    check("rev_x", head_x, 12);
    check("rev_dir", dir, 3);
    load(0);
    load(2);
    ticks(SF, 1);
    check("down_y", head_y, 16);
    check("down_dir", dir, 2);
    freeze = 1; cyc();
    start = 1; cyc();
    ticks(29 * SF, 0);
    check("wrapx_pre", head_x, 39);
    ticks(SF, 0);
    check("wrapx_x", head_x, 0);
    check("wrapx_y", head_y, 15);
    freeze = 1; cyc();
    start = 1; cyc();
    load(0);
    ticks(SF, 0);
    load(1);
    ticks(5 * SF, 0);
    check("leftpath_x", head_x, 5);
    load(0);
    ticks(14 * SF, 0);
    check("wrapy_pre", head_y, 0);
    ticks(SF, 0);
    check("wrapy_x", head_x, 5);
    check("wrapy_y", head_y, 29);
    ticks(SF - 1, 0);
    frame_tick = 1; freeze = 1; cyc();
    check("frz_pulse", step_pulse, 0);
    check("frz_running", running, 0);
    check("frz_y", head_y, 29);
    ticks(12, 0);
    load(1);
    check("halt_x", head_x, 5);
    check("halt_y", head_y, 29);
    start = 1; cyc();
    check("restart_x", head_x, 10);
    check("restart_y", head_y, 15);
    check("restart_dir", dir, 3);
    check("restart_running", running, 1);
    ticks(SF - 1, 0);
    frame_tick = 1; Reset_n = 0; cyc();
    Reset_n = 1;
    check("rst_x", head_x, 10);
    check("rst_y", head_y, 15);
    check("rst_pulse", step_pulse, 0);
    check("rst_running", running, 0);
    load(0);
    ticks(3, 0);
    start = 1; cyc();
    ticks(SF, 2);
    check("post_x", head_x, 11);
    check("post_dir", dir, 3);
    repeat (2) cyc();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_head_ctrl.md
# snake_head_ctrl

Converts the per-player `motionFlag`/`Load` key decode into committed snake motion: buffers the requested direction, blocks 180° reversals, and advances the head one grid cell per N video frames with wrap-around. It sits directly downstream of the key-to-direction decoders, one instance per snake, and feeds head coordinates to the body/trail buffer and the collision checker. Collision logic feeds back a `freeze` request that halts the snake until the next round start.

## Interface
- `GRID_W`, default 40: grid width in cells.
- `GRID_H`, default 30: grid height in cells.
- `STEP_FRAMES`, default 6: frame ticks per head step; legal range 1..63.
- `START_X`, default 10: head X after reset or restart.
- `START_Y`, default 15: head Y after reset or restart.
- `START_DIR`, default 2'b11 (right): direction after reset or restart.
- `Clk`  in  1: system clock.
- `Reset_n`  in  1: synchronous, active-low reset.
- `motionFlag`  in  2: requested direction. 00 up, 01 left, 10 down, 11 right.
- `Load`  in  1: level; 1 when `motionFlag` is a valid request this cycle.
- `frame_tick`  in  1: single-cycle pulse, once per video frame.
- `start`  in  1: single-cycle round-start pulse.
- `freeze`  in  1: single-cycle halt request from collision logic.
- `head_x`  out  $clog2(GRID_W): head column.
- `head_y`  out  $clog2(GRID_H): head row.
- `dir`  out  2: committed direction, same encoding as `motionFlag`.
- `step_pulse`  out  1: 1 for exactly the cycle in which new `head_x`/`head_y` first appear.
- `running`  out  1: 1 while in RUN.

## Operation
- State machine `IDLE`, `RUN`, `HALT`. Reset (`Reset_n`=0 at an edge) enters `IDLE` from any state, including mid-step.
- **IDLE**
  - Head is at `START_X`/`START_Y`, `dir`=`START_DIR`, pending direction=`START_DIR`, frame counter=0.
  - `start` moves to `RUN`.
  - `Load` is ignored.
- **RUN**
  - **Pending direction:** on any cycle with `Load`=1, the pending direction takes `motionFlag`, unless `motionFlag == dir ^ 2'b10` (reversal), which is dropped. The last accepted request before a step wins.
  - **Frame counter:** increments on `frame_tick`. On the tick where counter == `STEP_FRAMES-1`, the counter clears and a step occurs.
  - **Step**
    - `dir` takes the pending direction.
    - The head moves one cell in the new direction: up y−1, down y+1, left x−1, right x+1.
    - Wrap-around: x=0 moving left goes to `GRID_W-1`; x=`GRID_W-1` moving right goes to 0. Same for y with `GRID_H`.
    - Arithmetic is done at coordinate width with an explicit compare. Modulo-2^n wrap is not used, because GRID_W/H need not be powers of 2.
  - **Freeze:** `freeze` goes to `HALT`. If `freeze` and a step occur in the same cycle, `freeze` wins: no move and no `step_pulse`.
  - `start` in `RUN` is ignored.
- **HALT**
  - Head, `dir` and counter are held.
  - `Load` and `frame_tick` are ignored.
  - `start` reloads all start values and enters `RUN` directly.
- **Reset values:** `head_x`=`START_X`, `head_y`=`START_Y`, `dir`=`START_DIR`, `step_pulse`=0, `running`=0.

## Timing
- All outputs are registered.
- Step latency: with `frame_tick` high in cycle T and the counter at `STEP_FRAMES-1`, the new head and `dir` are visible at T+1, with `step_pulse`=1 during T+1 only.
- `Load` accepted at cycle T takes effect on the next step, no earlier than T+1.
- `running` goes to 1 the cycle after `start` is sampled in `IDLE`/`HALT`, and to 0 the cycle after `freeze`.
- The reversal check uses the committed `dir`, not the pending direction. Example: with pending=up and dir=right, a request for left is still rejected.

## Structure
- **Package `snake_pkg`:**
  - `dir_t` enum (UP=2'b00, LEFT=2'b01, DOWN=2'b10, RIGHT=2'b11).
  - `head_state_t` enum (IDLE, RUN, HALT).
  - Function `opposite(dir_t)` returning `dir ^ 2'b10`.
  - Shared with the decoders and the collision checker.
- **Sub-module `step_timer`:** frame counter with `clear`/`enable`, producing a one-cycle `step` strobe. It is reused by the food spawner.

## Test plan
- Reset, then `start`, then 6 `frame_tick`s with no `Load` → one `step_pulse`; head (10,15)→(11,15), `dir`=11.
- In `RUN` with `dir`=right, `Load`=1 with `motionFlag`=01 (left) → rejected; after the next step head x+1, `dir`=11.
- `dir`=right; `Load` with 00 (up), then `Load` with 10 (down) before the step → down accepted (only opposite of committed right is blocked); after the step y=16, `dir`=10.
- Head at (39,15) moving right, step → (0,15). Head at (5,0) moving up, step → (5,29).
- `freeze` in the same cycle as the stepping `frame_tick` → no move, `step_pulse`=0, `running`=0 next cycle. Further ticks have no effect. `start` → head (10,15), `dir`=11, `running`=1.
- `Reset_n`=0 asserted in the step cycle mid-run → next cycle head (10,15), `step_pulse`=0, state `IDLE`.
